// File: rtl/ocd_pkg.sv
// ocd_pkg -- shared definitions for the OCD level scheduler and period-synchronous blocks.
//   cnt_max_f : PWM period length in clk cycles (same arithmetic as ocd_lvl)
//   cnt_w_f   : register width needed to hold 0..cnt_max-1
//   clamp_f   : saturate a requested level at the configured maximum
//   state_e   : scheduler FSM states
package ocd_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        UP   = 2'd2,
        DN   = 2'd3
    } state_e;

    function automatic int cnt_max_f(input int clk_mhz, input int freq_khz);
        return (1000 * clk_mhz) / freq_khz;
    endfunction

    function automatic int cnt_w_f(input int cnt_max);
        return (cnt_max > 1) ? $clog2(cnt_max) : 1;
    endfunction

    function automatic int clamp_f(input int val, input int max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/period_tick.sv
// period_tick -- PWM period-boundary strobe, cycle-exact with the ocd_lvl counter.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   tick  out high for the single cycle in which the down-counter sits at 0
module period_tick
    import ocd_pkg::*;
#(
    parameter int CLK_MHZ  = 100,
    parameter int FREQ_KHZ = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_MAX = cnt_max_f(CLK_MHZ, FREQ_KHZ);
    localparam int CW      = cnt_w_f(CNT_MAX);
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? CNT_TOP : (cnt_q - CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= CNT_TOP;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/ocd_lvl_sched.sv
// ocd_lvl_sched -- arbitrates host/pot level requests and ramps the level applied
// to ocd_lvl (pw_par) toward the target, stepping only on PWM period boundaries.
//   clk, rst_n         clock, synchronous active-low reset
//   en                 level enable; low forces pw_par to 0 immediately
//   host_lock          blocks the pot port
//   a_valid/a_val/a_ready  host request port (priority)
//   b_valid/b_val/b_ready  pot request port
//   pw_par             applied level (registered)
//   busy               ramp in progress
//   done               one-cycle pulse after the ramp reaches its target
//   tick               period-boundary strobe
module ocd_lvl_sched
    import ocd_pkg::*;
#(
    parameter int CLK_MHZ     = 100,
    parameter int FREQ_KHZ    = 100,
    parameter int PAR_MAX_VAL = 100,
    parameter int STEP_UP     = 10,
    parameter int STEP_DN     = 100,
    parameter int INIT_VAL    = 0,
    localparam int W = (PAR_MAX_VAL > 0) ? $clog2(PAR_MAX_VAL + 1) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         host_lock,
    input  logic         a_valid,
    input  logic [W-1:0] a_val,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_val,
    output logic         b_ready,
    output logic [W-1:0] pw_par,
    output logic         busy,
    output logic         done,
    output logic         tick
);

    // Steps larger than the full range behave like the full range; limiting them
    // here keeps the constants inside the W+1 bit ramp arithmetic.
    localparam logic [W:0] STEP_UP_X = (W+1)'(clamp_f(STEP_UP, PAR_MAX_VAL));
    localparam logic [W:0] STEP_DN_X = (W+1)'(clamp_f(STEP_DN, PAR_MAX_VAL));
    localparam logic [W-1:0] TGT_INIT = W'(clamp_f(INIT_VAL, PAR_MAX_VAL));

    state_e       state_q, state_d;
    logic [W-1:0] cur_q, cur_d;
    logic [W-1:0] target_q, target_d;
    logic         done_q, done_d;

    logic [W:0]   cur_x, tgt_x, diff_x, step_x, next_x;

    period_tick #(
        .CLK_MHZ  (CLK_MHZ),
        .FREQ_KHZ (FREQ_KHZ)
    ) u_period_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Host always wins; ready is suppressed while reset is held.
    assign a_ready = a_valid & rst_n;
    assign b_ready = b_valid & ~a_valid & ~host_lock & rst_n;

    always_comb begin
        target_d = target_q;
        if (a_ready) begin
            target_d = W'(clamp_f(int'(a_val), PAR_MAX_VAL));
        end else if (b_ready) begin
            target_d = W'(clamp_f(int'(b_val), PAR_MAX_VAL));
        end
    end

    // One ramp step toward the target held before this edge, so a request that
    // lands on a tick edge only takes effect from the following tick.
    always_comb begin
        cur_x  = {1'b0, cur_q};
        tgt_x  = {1'b0, target_q};
        diff_x = '0;
        step_x = '0;
        next_x = cur_x;
        if (cur_x < tgt_x) begin
            diff_x = tgt_x - cur_x;
            step_x = (diff_x > STEP_UP_X) ? STEP_UP_X : diff_x;
            next_x = cur_x + step_x;
        end else if (cur_x > tgt_x) begin
            diff_x = cur_x - tgt_x;
            step_x = (diff_x > STEP_DN_X) ? STEP_DN_X : diff_x;
            next_x = cur_x - step_x;
        end
    end

    always_comb begin
        cur_d = cur_q;
        // Disable is a safety path: zero the level on this edge, no tick wait.
        // Leaving OFF also keeps cur at 0 so the ramp starts from zero.
        if (!en || state_q == OFF) begin
            cur_d = '0;
        end else if (tick) begin
            cur_d = next_x[W-1:0];
        end
    end

    // State follows the relation between the post-edge level and target, which
    // covers ramp completion, retargeting and the OFF exit in one rule.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = OFF;
        end else if (cur_d == target_d) begin
            state_d = IDLE;
        end else if (cur_d < target_d) begin
            state_d = UP;
        end else begin
            state_d = DN;
        end
        done_d = ((state_q == UP) || (state_q == DN)) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= OFF;
            cur_q    <= '0;
            target_q <= TGT_INIT;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    assign pw_par = cur_q;
    assign busy   = (state_q == UP) || (state_q == DN);
    assign done   = done_q;

endmodule
